// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned SD_DEF_PAT_W = 4;
  localparam logic [SD_DEF_PAT_W-1:0] SD_DEF_PAT = 4'b1011;
  localparam int unsigned SD_DEF_CNT_W = 16;

  // Detector phase, derived from how many history bits are valid.
  typedef enum logic [1:0] {
    SD_EMPTY   = 2'd0,
    SD_FILLING = 2'd1,
    SD_ARMED   = 2'd2
  } sd_phase_e;

  // Map the fill-level flags onto a phase; full takes precedence over empty.
  function automatic sd_phase_e sd_decode_phase(input logic fill_zero,
                                                input logic fill_full);
    sd_phase_e ph;
    if (fill_full) begin
      ph = SD_ARMED;
    end else if (fill_zero) begin
      ph = SD_EMPTY;
    end else begin
      ph = SD_FILLING;
    end
    return ph;
  endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// Saturating match counter; a clear coinciding with an increment loads 1.
module seq_det_match_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_nxt;

  // Next count: clear wins, otherwise increment until all ones.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime-loadable pattern,
// overlapping / non-overlapping detection and an optional match counter.
// Build option: define SEQ_DET_COUNT_EN to include the saturating counter;
// otherwise match_cnt is tied to zero and cnt_clr is ignored.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W     = SD_DEF_PAT_W,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(SD_DEF_PAT),
  parameter int unsigned      CNT_W     = SD_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [PAT_W-1:0] pattern,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned SH_W     = PAT_W - 1;
  localparam int unsigned FILL_W   = $clog2(PAT_W);
  localparam int unsigned FILL_MAX = PAT_W - 1;

  logic [SH_W-1:0]   sh_q;
  logic [SH_W-1:0]   sh_nxt;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_nxt;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  pat_nxt;
  logic              y_nxt;
  logic              armed_nxt;
  logic              fill_full_c;
  logic              match_c;
  sd_phase_e         phase_c;

  // State register: history, fill level, pattern and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q   <= '0;
      fill_q <= '0;
      pat_q  <= RESET_PAT;
      y      <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sh_q   <= sh_nxt;
      fill_q <= fill_nxt;
      pat_q  <= pat_nxt;
      y      <= y_nxt;
      armed  <= armed_nxt;
    end
  end

  // Next state: pattern load beats an accepted bit; a non-overlapping match restarts from empty.
  always_comb begin
    sh_nxt      = sh_q;
    fill_nxt    = fill_q;
    pat_nxt     = pat_q;
    y_nxt       = 1'b0;
    match_c     = 1'b0;
    fill_full_c = (fill_q == FILL_W'(FILL_MAX));
    phase_c     = sd_decode_phase(fill_q == '0, fill_full_c);

    if (pat_load) begin
      pat_nxt  = pat_in;
      sh_nxt   = '0;
      fill_nxt = '0;
    end else if (x_valid) begin
      match_c = (phase_c == SD_ARMED) && ({sh_q, x} == pat_q);
      y_nxt   = match_c;
      if (match_c && !overlap) begin
        sh_nxt   = '0;
        fill_nxt = '0;
      end else begin
        sh_nxt = SH_W'({sh_q, x});
        if (!fill_full_c) begin
          fill_nxt = fill_q + FILL_W'(1);
        end
      end
    end

    armed_nxt = (fill_nxt == FILL_W'(FILL_MAX));
  end

  assign pattern = pat_q;

`ifdef SEQ_DET_COUNT_EN
  // Match counter, updated on the same edge that raises y.
  seq_det_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_c),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );
`else
  // Counter compiled out: constant zero count, clear input has no effect.
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (default, 8-bit and 2-bit-counter instances).
module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       x_valid;
  logic       x;
  logic       pat_load;
  logic [3:0] pat_in;
  logic [7:0] pat_in8;
  logic       overlap;
  logic       cnt_clr;

  logic        y,  armed;
  logic [3:0]  pattern;
  logic [15:0] match_cnt;

  logic        y8, armed8;
  logic [7:0]  pattern8;
  logic [15:0] match_cnt8;

  logic        yc, armedc;
  logic [3:0]  patternc;
  logic [1:0]  match_cntc;

  int tests = 0;
  int fails = 0;

  logic [6:0]  s7;
  logic [6:0]  e7;
  logic [6:0]  gv;
  logic [3:0]  s4;
  logic [3:0]  e4;
  logic [15:0] s16;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr), .y(y),
    .pattern(pattern), .armed(armed), .match_cnt(match_cnt)
  );

  seq_detector_param #(.PAT_W(8), .RESET_PAT(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in8), .overlap(overlap), .cnt_clr(cnt_clr), .y(y8),
    .pattern(pattern8), .armed(armed8), .match_cnt(match_cnt8)
  );

  seq_detector_param #(.PAT_W(4), .RESET_PAT(4'b1111), .CNT_W(2)) dutc (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr), .y(yc),
    .pattern(patternc), .armed(armedc), .match_cnt(match_cntc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic cyc(input logic v, input logic b, input logic ld, input logic clr);
    @(negedge clk);
    x_valid  = v;
    x        = b;
    pat_load = ld;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    x_valid  = 1'b0;
    x        = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; x_valid = 1'b0; x = 1'b0; pat_load = 1'b0;
    pat_in = 4'd0; pat_in8 = 8'd0; overlap = 1'b0; cnt_clr = 1'b0;

    // Reset state
    do_reset();
    chk("rst_y", 32'(y), 0);
    chk("rst_pattern", 32'(pattern), 32'hB);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_pattern8", 32'(pattern8), 32'hA5);
    chk("rst_patternc", 32'(patternc), 32'hF);

    // Overlapping detection of 1011 in 1011011
    overlap = 1'b1;
    s7 = 7'b1011011;
    e7 = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, s7[6-i], 1'b0, 1'b0);
      chk($sformatf("ovl_y%0d", i), 32'(y), 32'(e7[6-i]));
      if (i == 2) chk("ovl_armed", 32'(armed), 1);
    end
    chk("ovl_cnt", 32'(match_cnt), cnt_exp(2));

    // Non-overlapping detection on the same stream
    do_reset();
    overlap = 1'b0;
    e7 = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, s7[6-i], 1'b0, 1'b0);
      chk($sformatf("novl_y%0d", i), 32'(y), 32'(e7[6-i]));
      if (i == 3) chk("novl_armed", 32'(armed), 0);
    end
    chk("novl_cnt", 32'(match_cnt), cnt_exp(1));

    // Gapped valid stream, then pattern load colliding with a valid bit
    do_reset();
    overlap = 1'b1;
    gv = 7'b1010101;
    s7 = 7'b1001101;
    e7 = 7'b0000001;
    for (int i = 0; i < 7; i++) begin
      cyc(gv[6-i], s7[6-i], 1'b0, 1'b0);
      chk($sformatf("gap_y%0d", i), 32'(y), 32'(e7[6-i]));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_y_idle", 32'(y), 0);
    pat_in = 4'b0110;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("ld_pattern", 32'(pattern), 32'h6);
    chk("ld_armed", 32'(armed), 0);
    chk("ld_y", 32'(y), 0);
    s4 = 4'b0110;
    e4 = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, s4[3-i], 1'b0, 1'b0);
      chk($sformatf("ld_y%0d", i), 32'(y), 32'(e4[3-i]));
      if (i == 1) chk("ld_armed1", 32'(armed), 0);
      if (i == 2) chk("ld_armed2", 32'(armed), 1);
    end

    // 8-bit instance, pattern A5, non-overlapping
    do_reset();
    overlap = 1'b0;
    s16 = 16'hA5A5;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, s16[15-i], 1'b0, 1'b0);
      chk($sformatf("w8_y%0d", i), 32'(y8), ((i == 7) || (i == 15)) ? 32'd1 : 32'd0);
    end
    chk("w8_cnt", 32'(match_cnt8), cnt_exp(2));

    // 2-bit counter saturation with pattern 1111 and overlap
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("c_y%0d", i), 32'(yc), (i >= 3) ? 32'd1 : 32'd0);
      if (i == 3) chk("c_cnt1", 32'(match_cntc), cnt_exp(1));
      if (i >= 5) chk($sformatf("c_sat%0d", i), 32'(match_cntc), cnt_exp(3));
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_match_y", 32'(yc), 1);
    chk("clr_match_cnt", 32'(match_cntc), cnt_exp(1));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_alone_cnt", 32'(match_cntc), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while armed with a loaded pattern
    do_reset();
    overlap = 1'b1;
    pat_in = 4'b1101;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    s4 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, s4[3-i], 1'b0, 1'b0);
    end
    chk("ar_pre_y", 32'(y), 1);
    chk("ar_pre_armed", 32'(armed), 1);
    chk("ar_pre_cnt", 32'(match_cnt), cnt_exp(1));
    chk("ar_pre_pattern", 32'(pattern), 32'hD);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_y", 32'(y), 0);
    chk("ar_armed", 32'(armed), 0);
    chk("ar_cnt", 32'(match_cnt), 0);
    chk("ar_pattern", 32'(pattern), 32'hB);
    @(negedge clk);
    rst = 1'b1;
    s4 = 4'b1011;
    e4 = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, s4[3-i], 1'b0, 1'b0);
      chk($sformatf("ar_post_y%0d", i), 32'(y), 32'(e4[3-i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
